// File: rtl/dkong3_objram_arb.sv
// Three-way arbiter for the single-port object (sprite) RAM.
// Requesters: video sprite fetch (VID), sprite DMA (DMA) and the Z80 CPU (CPU).
// One access at a time: IDLE (arbitrate) -> ACC (RAM sees address/WE) ->
// RDW (reads only, capture RAM data) -> IDLE. ACK pulses for one cycle, and
// that cycle masks the acknowledged requester so that a held REQ is not
// serviced twice.
module dkong3_objram_arb #(
  parameter int unsigned AW         = 10,
  parameter int unsigned DW         = 8,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic          I_CLK,
  input  logic          I_RSTn,
  // video sprite fetch (read only)
  input  logic          I_VID_REQ,
  input  logic [AW-1:0] I_VID_A,
  output logic [DW-1:0] O_VID_Q,
  output logic          O_VID_ACK,
  // sprite DMA
  input  logic          I_DMA_REQ,
  input  logic          I_DMA_WE,
  input  logic [AW-1:0] I_DMA_A,
  input  logic [DW-1:0] I_DMA_D,
  input  logic          I_DMA_LOCK,
  output logic [DW-1:0] O_DMA_Q,
  output logic          O_DMA_ACK,
  // Z80 CPU
  input  logic          I_CPU_REQ,
  input  logic          I_CPU_WE,
  input  logic [AW-1:0] I_CPU_A,
  input  logic [DW-1:0] I_CPU_D,
  output logic [DW-1:0] O_CPU_Q,
  output logic          O_CPU_ACK,
  output logic          O_CPU_WAIT,
  // object RAM
  output logic [AW-1:0] O_RAM_A,
  output logic [DW-1:0] O_RAM_D,
  output logic          O_RAM_WE,
  input  logic [DW-1:0] I_RAM_Q
);

  typedef enum logic [1:0] {StIdle, StAcc, StRdw} state_e;
  typedef enum logic [1:0] {OwnVid, OwnDma, OwnCpu} owner_e;

  localparam logic [7:0] StarveMax = 8'(STARVE_MAX);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [AW-1:0] ram_a_q, ram_a_d;
  logic [DW-1:0] ram_d_q, ram_d_d;
  logic          ram_we_q, ram_we_d;
  logic          vid_ack_q, vid_ack_d;
  logic          dma_ack_q, dma_ack_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [DW-1:0] vid_rd_q, vid_rd_d;
  logic [DW-1:0] dma_rd_q, dma_rd_d;
  logic [DW-1:0] cpu_rd_q, cpu_rd_d;
  logic [7:0]    starve_q, starve_d;

  logic vid_elig, dma_elig, cpu_elig, starved;
  logic gnt_vid, gnt_dma, gnt_cpu, gnt_cpu_hi;

  // Eligibility and fixed-priority winner, with the starved CPU jumping DMA.
  always_comb begin
    vid_elig   = I_VID_REQ & ~vid_ack_q;
    dma_elig   = I_DMA_REQ & ~dma_ack_q;
    cpu_elig   = I_CPU_REQ & ~cpu_ack_q & ~I_DMA_LOCK;
    starved    = (starve_q == StarveMax);
    gnt_vid    = vid_elig;
    gnt_cpu_hi = ~vid_elig & cpu_elig & starved;
    gnt_dma    = ~vid_elig & ~gnt_cpu_hi & dma_elig;
    gnt_cpu    = gnt_cpu_hi | (~vid_elig & ~dma_elig & cpu_elig);
  end

  // Access sequencer: next state, RAM drive, ACK pulses and read capture.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ram_a_d   = ram_a_q;
    ram_d_d   = ram_d_q;
    ram_we_d  = 1'b0;
    vid_ack_d = 1'b0;
    dma_ack_d = 1'b0;
    cpu_ack_d = 1'b0;
    vid_rd_d  = vid_rd_q;
    dma_rd_d  = dma_rd_q;
    cpu_rd_d  = cpu_rd_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_vid) begin
          owner_d  = OwnVid;
          ram_a_d  = I_VID_A;
          ram_d_d  = '0;
          ram_we_d = 1'b0;
          state_d  = StAcc;
        end else if (gnt_dma) begin
          owner_d  = OwnDma;
          ram_a_d  = I_DMA_A;
          ram_d_d  = I_DMA_D;
          ram_we_d = I_DMA_WE;
          state_d  = StAcc;
        end else if (gnt_cpu) begin
          owner_d  = OwnCpu;
          ram_a_d  = I_CPU_A;
          ram_d_d  = I_CPU_D;
          ram_we_d = I_CPU_WE;
          state_d  = StAcc;
        end
      end
      StAcc: begin
        // ram_we_q still holds the granted access type during ACC
        if (ram_we_q) begin
          vid_ack_d = (owner_q == OwnVid);
          dma_ack_d = (owner_q == OwnDma);
          cpu_ack_d = (owner_q == OwnCpu);
          state_d   = StIdle;
        end else begin
          state_d = StRdw;
        end
      end
      StRdw: begin
        unique case (owner_q)
          OwnVid: begin
            vid_rd_d  = I_RAM_Q;
            vid_ack_d = 1'b1;
          end
          OwnDma: begin
            dma_rd_d  = I_RAM_Q;
            dma_ack_d = 1'b1;
          end
          default: begin
            cpu_rd_d  = I_RAM_Q;
            cpu_ack_d = 1'b1;
          end
        endcase
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // CPU starvation counter: counts lost IDLE decisions, saturating.
  always_comb begin
    starve_d = starve_q;
    if (!I_CPU_REQ || I_DMA_LOCK) begin
      starve_d = '0;
    end else if (state_q == StIdle) begin
      if (gnt_cpu) begin
        starve_d = '0;
      end else if (cpu_elig && !starved) begin
        starve_d = starve_q + 8'd1;
      end
    end
  end

  // State registers; reset aborts any access in flight without an ACK.
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q   <= StIdle;
      owner_q   <= OwnVid;
      ram_a_q   <= '0;
      ram_d_q   <= '0;
      ram_we_q  <= 1'b0;
      vid_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      vid_rd_q  <= '0;
      dma_rd_q  <= '0;
      cpu_rd_q  <= '0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ram_a_q   <= ram_a_d;
      ram_d_q   <= ram_d_d;
      ram_we_q  <= ram_we_d;
      vid_ack_q <= vid_ack_d;
      dma_ack_q <= dma_ack_d;
      cpu_ack_q <= cpu_ack_d;
      vid_rd_q  <= vid_rd_d;
      dma_rd_q  <= dma_rd_d;
      cpu_rd_q  <= cpu_rd_d;
      starve_q  <= starve_d;
    end
  end

  // Output wiring; WAIT stays combinational so the Z80 is released on the ACK cycle.
  always_comb begin
    O_RAM_A    = ram_a_q;
    O_RAM_D    = ram_d_q;
    O_RAM_WE   = ram_we_q;
    O_VID_ACK  = vid_ack_q;
    O_DMA_ACK  = dma_ack_q;
    O_CPU_ACK  = cpu_ack_q;
    O_VID_Q    = vid_rd_q;
    O_DMA_Q    = dma_rd_q;
    O_CPU_Q    = cpu_rd_q;
    O_CPU_WAIT = I_CPU_REQ & ~cpu_ack_q;
  end

endmodule

// File: tb/tb_dkong3_objram_arb.sv
// Bench for dkong3_objram_arb: a behavioural sync-read RAM, requester drivers,
// and a scoreboard of expected ACK order (and read data) checked by a monitor.
module tb_dkong3_objram_arb;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam logic [1:0] WVid = 2'd0;
  localparam logic [1:0] WDma = 2'd1;
  localparam logic [1:0] WCpu = 2'd2;

  logic          I_CLK = 1'b0;
  logic          I_RSTn;
  logic          I_VID_REQ;
  logic [AW-1:0] I_VID_A;
  logic [DW-1:0] O_VID_Q;
  logic          O_VID_ACK;
  logic          I_DMA_REQ, I_DMA_WE, I_DMA_LOCK;
  logic [AW-1:0] I_DMA_A;
  logic [DW-1:0] I_DMA_D;
  logic [DW-1:0] O_DMA_Q;
  logic          O_DMA_ACK;
  logic          I_CPU_REQ, I_CPU_WE;
  logic [AW-1:0] I_CPU_A;
  logic [DW-1:0] I_CPU_D;
  logic [DW-1:0] O_CPU_Q;
  logic          O_CPU_ACK, O_CPU_WAIT;
  logic [AW-1:0] O_RAM_A;
  logic [DW-1:0] O_RAM_D;
  logic          O_RAM_WE;
  logic [DW-1:0] I_RAM_Q;

  dkong3_objram_arb #(.AW(AW), .DW(DW), .STARVE_MAX(8)) dut (
    .I_CLK(I_CLK), .I_RSTn(I_RSTn),
    .I_VID_REQ(I_VID_REQ), .I_VID_A(I_VID_A), .O_VID_Q(O_VID_Q), .O_VID_ACK(O_VID_ACK),
    .I_DMA_REQ(I_DMA_REQ), .I_DMA_WE(I_DMA_WE), .I_DMA_A(I_DMA_A), .I_DMA_D(I_DMA_D),
    .I_DMA_LOCK(I_DMA_LOCK), .O_DMA_Q(O_DMA_Q), .O_DMA_ACK(O_DMA_ACK),
    .I_CPU_REQ(I_CPU_REQ), .I_CPU_WE(I_CPU_WE), .I_CPU_A(I_CPU_A), .I_CPU_D(I_CPU_D),
    .O_CPU_Q(O_CPU_Q), .O_CPU_ACK(O_CPU_ACK), .O_CPU_WAIT(O_CPU_WAIT),
    .O_RAM_A(O_RAM_A), .O_RAM_D(O_RAM_D), .O_RAM_WE(O_RAM_WE), .I_RAM_Q(I_RAM_Q)
  );

  always #5 I_CLK = ~I_CLK;

  // Object RAM model: write strobe and one-cycle synchronous read.
  logic [DW-1:0] mem [0:1023];
  always @(posedge I_CLK) begin
    if (O_RAM_WE) mem[O_RAM_A] <= O_RAM_D;
    I_RAM_Q <= mem[O_RAM_A];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: no ACK within cycle budget at %0t", name, $time);
  endtask

  typedef struct packed {
    logic [1:0] who;
    logic       chk;
    logic [7:0] q;
  } exp_t;
  exp_t sb[$];

  task automatic push(input logic [1:0] who, input logic chk, input logic [7:0] q);
    exp_t e;
    e.who = who;
    e.chk = chk;
    e.q   = q;
    sb.push_back(e);
  endtask

  // Monitor: every ACK must match the head of the expected queue.
  int         n_ack;
  logic [1:0] mon_who;
  logic [7:0] mon_q;
  exp_t       mon_e;
  always @(negedge I_CLK) begin
    if (I_RSTn) begin
      n_ack = int'(O_VID_ACK) + int'(O_DMA_ACK) + int'(O_CPU_ACK);
      if (n_ack > 1) begin
        check("single_ack", n_ack, 1);
      end else if (n_ack == 1) begin
        mon_who = O_VID_ACK ? WVid : (O_DMA_ACK ? WDma : WCpu);
        mon_q   = O_VID_ACK ? O_VID_Q : (O_DMA_ACK ? O_DMA_Q : O_CPU_Q);
        if (sb.size() == 0) begin
          check("unexpected_ack_owner", int'(mon_who), 3);
        end else begin
          mon_e = sb.pop_front();
          check("ack_owner", int'(mon_who), int'(mon_e.who));
          if (mon_e.chk) check("ack_rdata", int'(mon_q), int'(mon_e.q));
        end
      end
    end
  end

  // Requester drivers: hold REQ across consecutive accesses, drop after n ACKs.
  task automatic vid_run(input int n, input logic [AW-1:0] a0, input int lim);
    int k = 0;
    int t = 0;
    I_VID_A = a0;
    I_VID_REQ = 1'b1;
    while (k < n) begin
      @(negedge I_CLK);
      t++;
      if (O_VID_ACK) begin
        k++;
        t = 0;
        I_VID_A = I_VID_A + 10'd1;
      end else if (t > lim) begin
        timeout("vid_req");
        k = n;
      end
    end
    I_VID_REQ = 1'b0;
  endtask

  task automatic dma_run(input int n, input logic we, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input int lim);
    int k = 0;
    int t = 0;
    I_DMA_WE = we;
    I_DMA_A = a0;
    I_DMA_D = d0;
    I_DMA_REQ = 1'b1;
    while (k < n) begin
      @(negedge I_CLK);
      t++;
      if (O_DMA_ACK) begin
        k++;
        t = 0;
        I_DMA_A = I_DMA_A + 10'd1;
        I_DMA_D = I_DMA_D + 8'd1;
      end else if (t > lim) begin
        timeout("dma_req");
        k = n;
      end
    end
    I_DMA_REQ = 1'b0;
  endtask

  task automatic cpu_run(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int lim);
    int t = 0;
    I_CPU_WE = we;
    I_CPU_A = a;
    I_CPU_D = d;
    I_CPU_REQ = 1'b1;
    do begin
      @(negedge I_CLK);
      t++;
    end while (!O_CPU_ACK && t <= lim);
    if (!O_CPU_ACK) timeout("cpu_req");
    I_CPU_REQ = 1'b0;
  endtask

  initial begin
    I_RSTn = 1'b0;
    I_VID_REQ = 0; I_VID_A = '0;
    I_DMA_REQ = 0; I_DMA_WE = 0; I_DMA_A = '0; I_DMA_D = '0; I_DMA_LOCK = 0;
    I_CPU_REQ = 0; I_CPU_WE = 0; I_CPU_A = '0; I_CPU_D = '0;
    #12;
    check("rst_ram_a", int'(O_RAM_A), 0);
    check("rst_ram_d", int'(O_RAM_D), 0);
    check("rst_ram_we", int'(O_RAM_WE), 0);
    check("rst_acks", int'({O_VID_ACK, O_DMA_ACK, O_CPU_ACK}), 0);
    check("rst_qs", int'({O_VID_Q, O_DMA_Q, O_CPU_Q}), 0);
    @(negedge I_CLK);
    I_RSTn = 1'b1;
    @(negedge I_CLK);

    // 1: lone CPU write, ACK on the second cycle
    push(WCpu, 1'b0, 8'h00);
    I_CPU_WE = 1'b1; I_CPU_A = 10'h155; I_CPU_D = 8'hA5; I_CPU_REQ = 1'b1;
    @(negedge I_CLK);
    check("t1_we_c1", int'(O_RAM_WE), 1);
    check("t1_addr", int'(O_RAM_A), 'h155);
    check("t1_data", int'(O_RAM_D), 'hA5);
    check("t1_wait_c1", int'(O_CPU_WAIT), 1);
    check("t1_ack_c1", int'(O_CPU_ACK), 0);
    @(negedge I_CLK);
    check("t1_we_c2", int'(O_RAM_WE), 0);
    check("t1_ack_c2", int'(O_CPU_ACK), 1);
    I_CPU_REQ = 1'b0;
    @(negedge I_CLK);

    // 2: CPU read back, ACK on the third cycle with data
    push(WCpu, 1'b1, 8'hA5);
    I_CPU_WE = 1'b0; I_CPU_A = 10'h155; I_CPU_REQ = 1'b1;
    @(negedge I_CLK);
    check("t2_we_c1", int'(O_RAM_WE), 0);
    check("t2_addr", int'(O_RAM_A), 'h155);
    @(negedge I_CLK);
    check("t2_ack_c2", int'(O_CPU_ACK), 0);
    check("t2_wait_c2", int'(O_CPU_WAIT), 1);
    @(negedge I_CLK);
    check("t2_ack_c3", int'(O_CPU_ACK), 1);
    check("t2_wait_c3", int'(O_CPU_WAIT), 0);
    check("t2_q", int'(O_CPU_Q), 'hA5);
    I_CPU_REQ = 1'b0;
    @(negedge I_CLK);

    // 3: simultaneous requests -> VID, DMA, CPU
    push(WVid, 1'b1, 8'hA5);
    push(WDma, 1'b0, 8'h00);
    push(WCpu, 1'b1, 8'h77);
    fork
      vid_run(1, 10'h155, 20);
      dma_run(1, 1'b1, 10'h020, 8'h77, 20);
      cpu_run(1'b0, 10'h020, 8'h00, 40);
    join
    @(negedge I_CLK);

    // 4: VID and DMA saturate the RAM; CPU wins over DMA after 8 lost rounds
    for (int i = 0; i < 4; i++) begin
      push(WVid, 1'b0, 8'h00);
      push(WDma, 1'b0, 8'h00);
    end
    push(WVid, 1'b0, 8'h00);
    push(WCpu, 1'b0, 8'h00);
    push(WDma, 1'b0, 8'h00);
    fork
      vid_run(5, 10'h300, 20);
      dma_run(5, 1'b1, 10'h200, 8'h10, 20);
      cpu_run(1'b1, 10'h3F0, 8'h99, 100);
    join
    @(negedge I_CLK);

    // 5: locked DMA burst of 0x19F writes excludes the CPU until unlock
    for (int i = 0; i < 'h19F; i++) push(WDma, 1'b0, 8'h00);
    push(WCpu, 1'b1, 8'h01);
    I_DMA_LOCK = 1'b1;
    fork
      begin
        dma_run('h19F, 1'b1, 10'h000, 8'h01, 20);
        I_DMA_LOCK = 1'b0;
      end
      cpu_run(1'b0, 10'h100, 8'h00, 3000);
    join
    @(negedge I_CLK);

    // 6: reset during the ACC cycle of a write
    push(WCpu, 1'b0, 8'h00);
    I_CPU_WE = 1'b1; I_CPU_A = 10'h0AA; I_CPU_D = 8'h3C; I_CPU_REQ = 1'b1;
    @(posedge I_CLK);
    #1;
    check("t6_we_grant", int'(O_RAM_WE), 1);
    #1 I_RSTn = 1'b0;
    #1;
    check("t6_we_async", int'(O_RAM_WE), 0);
    check("t6_no_ack", int'(O_CPU_ACK), 0);
    @(posedge I_CLK);
    #1;
    check("t6_ack_in_rst", int'(O_CPU_ACK), 0);
    @(negedge I_CLK);
    I_RSTn = 1'b1;
    begin
      int t = 0;
      do begin
        @(negedge I_CLK);
        t++;
      end while (!O_CPU_ACK && t <= 10);
      if (!O_CPU_ACK) timeout("t6_regrant");
      else check("t6_regrant_lat", t, 2);
    end
    I_CPU_REQ = 1'b0;
    check("t6_mem", int'(mem[10'h0AA]), 'h3C);

    repeat (5) @(negedge I_CLK);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
